ttl_74194_param_sync: RTL and testbench

Parametrised synchronous universal shift register modelling the 74LS194/74LS299 family on the system clock. Generalises the serial-in/parallel-out TTL register with configurable width, bidirectional shift, parallel load and a selectable clock-enable mode (rising-edge of `Cen` or level). Instantiated in video and sound shift paths where a board-level universal register is clocked from a derived TTL clock expressed as a `Cen` strobe.

---
 rtl/ttl_pkg.sv | 15 +
 rtl/ttl_cen_edge.sv | 36 +++
 rtl/ttl_74194_param_sync.sv | 71 +++++++
 tb/tb_ttl_74194_param_sync.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_pkg.sv
// Shared definitions for the synchronous TTL register models.
// Mode encoding follows the S1:S0 pins of the 74194 family.
package ttl_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD     = 2'b00,
        MODE_SHL_UP   = 2'b01,
        MODE_SHR_DOWN = 2'b10,
        MODE_LOAD     = 2'b11
    } ttl_mode_t;

    // Preset high so a Cen already asserted at reset release is not an edge.
    localparam logic LAST_CEN_RST = 1'b1;

endpackage

// File: rtl/ttl_cen_edge.sv
// Converts the Cen strobe into a per-cycle fire signal.
// EDGE=1 detects a rising edge against the previous clk cycle, EDGE=0 passes the level.
module ttl_cen_edge
    import ttl_pkg::*;
#(
    parameter bit EDGE = 1'b1
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic Cen,
    output logic fire
);

    logic last_cen_q;
    logic last_cen_d;

    // Tracks Cen unconditionally, so edges during a master clear are consumed.
    assign last_cen_d = Cen;

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            last_cen_q <= LAST_CEN_RST;
        end else begin
            last_cen_q <= last_cen_d;
        end
    end

    generate
        if (EDGE) begin : g_edge
            assign fire = Cen & ~last_cen_q;
        end else begin : g_level
            assign fire = Cen;
        end
    endgenerate

endmodule

// File: rtl/ttl_74194_param_sync.sv
// Parametrised 74LS194-style universal shift register on the system clock.
// Acts on each Cen fire; Q[WIDTH-1] and Q[0] double as cascade outputs.
module ttl_74194_param_sync
    import ttl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit CEN_EDGE = 1'b1
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             Cen,
    input  logic             MRn,
    input  logic [1:0]       S,
    input  logic             DSR,
    input  logic             DSL,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             evt
);

    logic             fire;
    ttl_mode_t        mode;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             evt_q;
    logic             evt_d;

    ttl_cen_edge #(
        .EDGE (CEN_EDGE)
    ) u_cen_edge (
        .clk     (clk),
        .Reset_n (Reset_n),
        .Cen     (Cen),
        .fire    (fire)
    );

    assign mode = ttl_mode_t'(S);

    // Shifted-out bits are discarded; no wrap-around.
    always_comb begin
        q_d = q_q;
        case (mode)
            MODE_HOLD:     q_d = q_q;
            MODE_SHL_UP:   q_d = {q_q[WIDTH-2:0], DSR};
            MODE_SHR_DOWN: q_d = {DSL, q_q[WIDTH-1:1]};
            MODE_LOAD:     q_d = D;
            default:       q_d = q_q;
        endcase
    end

    assign evt_d = fire;

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            q_q   <= '0;
            evt_q <= 1'b0;
        end else if (!MRn) begin
            q_q   <= '0;
            evt_q <= 1'b0;
        end else begin
            if (fire) begin
                q_q <= q_d;
            end
            evt_q <= evt_d;
        end
    end

    assign Q   = q_q;
    assign evt = evt_q;

endmodule

// File: tb/tb_ttl_74194_param_sync.sv
// Bench for ttl_74194_param_sync: an edge-mode 8-bit and a level-mode 12-bit instance
// share one stimulus stream and are both compared every cycle against a behavioural model.
module tb_ttl_74194_param_sync;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cen;
    logic        mrn;
    logic [1:0]  s;
    logic        dsr;
    logic        dsl;
    logic [11:0] d;
    logic [7:0]  q8;
    logic        evt8;
    logic [11:0] q12;
    logic        evt12;

    int errors = 0;
    int checks = 0;

    logic [21:0] exp_q[$];
    logic [21:0] obs_q[$];

    logic [7:0]  m_q8;
    logic        m_e8;
    logic        m_last8;
    logic [11:0] m_q12;
    logic        m_e12;

    always #5 clk = ~clk;

    ttl_74194_param_sync #(.WIDTH(8), .CEN_EDGE(1'b1)) dut8 (
        .clk(clk), .Reset_n(rstn), .Cen(cen), .MRn(mrn), .S(s),
        .DSR(dsr), .DSL(dsl), .D(d[7:0]), .Q(q8), .evt(evt8)
    );

    ttl_74194_param_sync #(.WIDTH(12), .CEN_EDGE(1'b0)) dut12 (
        .clk(clk), .Reset_n(rstn), .Cen(cen), .MRn(mrn), .S(s),
        .DSR(dsr), .DSL(dsl), .D(d), .Q(q12), .evt(evt12)
    );

    function automatic logic [11:0] mnext(input logic [11:0] q, input int w,
                                          input logic [1:0] sm, input logic r,
                                          input logic l, input logic [11:0] dd);
        logic [11:0] mask;
        logic [11:0] res;
        mask = 12'hFFF >> (12 - w);
        case (sm)
            2'b01:   res = ((q << 1) | {11'b0, r}) & mask;
            2'b10:   res = ((q & mask) >> 1) | ({11'b0, l} << (w - 1));
            2'b11:   res = dd & mask;
            default: res = q;
        endcase
        return res;
    endfunction

    // Model the coming clock edge, queue the expectation, then capture the DUT output.
    task automatic tick();
        logic        ev8;
        logic [11:0] t;
        ev8 = cen & ~m_last8;
        if (!rstn) begin
            m_q8 = 8'h00; m_e8 = 1'b0; m_last8 = 1'b1;
            m_q12 = 12'h000; m_e12 = 1'b0;
        end else begin
            m_last8 = cen;
            if (!mrn) begin
                m_q8 = 8'h00; m_e8 = 1'b0;
                m_q12 = 12'h000; m_e12 = 1'b0;
            end else begin
                if (ev8) begin
                    t = mnext({4'h0, m_q8}, 8, s, dsr, dsl, d);
                    m_q8 = t[7:0];
                end
                m_e8 = ev8;
                if (cen) m_q12 = mnext(m_q12, 12, s, dsr, dsl, d);
                m_e12 = cen;
            end
        end
        exp_q.push_back({m_e8, m_q8, m_e12, m_q12});
        @(posedge clk);
        #1;
        obs_q.push_back({evt8, q8, evt12, q12});
    endtask

    task automatic test_reset();
        logic [21:0] e, o;
        rstn = 1'b0; mrn = 1'b1; cen = 1'b1; s = 2'b11; d = 12'h0A5; dsr = 1'b0; dsl = 1'b0;
        tick(); tick();
        checks++;
        if (q8 !== 8'h00 || evt8 !== 1'b0) begin
            errors++; $display("FAIL reset_state got q=%h evt=%b want q=00 evt=0", q8, evt8);
        end
        rstn = 1'b1;
        tick(); tick();
        checks++;
        if (q8 !== 8'h00) begin
            errors++; $display("FAIL reset_edge_suppress got q=%h want 00", q8);
        end
        cen = 1'b0; tick();
        cen = 1'b1; tick();
        checks++;
        if (q8 !== 8'hA5 || evt8 !== 1'b1) begin
            errors++; $display("FAIL reset_first_edge got q=%h evt=%b want q=a5 evt=1", q8, evt8);
        end
        tick();
        checks++;
        if (evt8 !== 1'b0) begin
            errors++; $display("FAIL reset_evt_single got evt=%b want 0", evt8);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset_seq got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_shift_up();
        logic [21:0] e, o;
        cen = 1'b0; mrn = 1'b0; tick();
        mrn = 1'b1; s = 2'b01; dsr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cen = 1'b1; tick();
            cen = 1'b0; tick();
        end
        checks++;
        if (q8 !== 8'h07) begin
            errors++; $display("FAIL shift_up_three got q=%h want 07", q8);
        end
        dsr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cen = 1'b1; tick();
            cen = 1'b0; tick();
        end
        checks++;
        if (q8 !== 8'h00) begin
            errors++; $display("FAIL shift_up_no_wrap got q=%h want 00", q8);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL shift_up_seq got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_shift_down();
        logic [21:0] e, o;
        s = 2'b11; d = 12'h081;
        cen = 1'b1; tick(); cen = 1'b0; tick();
        s = 2'b10; dsl = 1'b0;
        cen = 1'b1; tick(); cen = 1'b0; tick();
        checks++;
        if (q8 !== 8'h40) begin
            errors++; $display("FAIL shift_down_first got q=%h want 40", q8);
        end
        dsl = 1'b1;
        cen = 1'b1; tick(); cen = 1'b0; tick();
        checks++;
        if (q8 !== 8'hA0) begin
            errors++; $display("FAIL shift_down_second got q=%h want a0", q8);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL shift_down_seq got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_mrn_vs_edge();
        logic [21:0] e, o;
        cen = 1'b0; tick();
        s = 2'b11; d = 12'h0FF; mrn = 1'b0; cen = 1'b1; tick();
        checks++;
        if (q8 !== 8'h00 || evt8 !== 1'b0) begin
            errors++; $display("FAIL mrn_clear got q=%h evt=%b want q=00 evt=0", q8, evt8);
        end
        mrn = 1'b1; tick(); tick();
        checks++;
        if (q8 !== 8'h00 || evt8 !== 1'b0) begin
            errors++; $display("FAIL mrn_edge_lost got q=%h evt=%b want q=00 evt=0", q8, evt8);
        end
        cen = 1'b0; tick(); cen = 1'b1; tick();
        checks++;
        if (q8 !== 8'hFF || evt8 !== 1'b1) begin
            errors++; $display("FAIL mrn_next_edge got q=%h evt=%b want q=ff evt=1", q8, evt8);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL mrn_seq got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_level_mode();
        logic [21:0] e, o;
        cen = 1'b0; mrn = 1'b0; tick();
        mrn = 1'b1; s = 2'b01; dsr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cen = 1'b1; tick();
            checks++;
            if (evt12 !== 1'b1) begin
                errors++; $display("FAIL level_evt cycle %0d got evt=%b want 1", i, evt12);
            end
        end
        checks++;
        if (q12 !== 12'h00F) begin
            errors++; $display("FAIL level_shift got q=%h want 00f", q12);
        end
        cen = 1'b0; tick();
        checks++;
        if (evt12 !== 1'b0 || q12 !== 12'h00F) begin
            errors++; $display("FAIL level_stop got q=%h evt=%b want q=00f evt=0", q12, evt12);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL level_seq got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_hold_event();
        logic [21:0] e, o;
        s = 2'b11; d = 12'h03C; cen = 1'b0; tick();
        cen = 1'b1; tick(); cen = 1'b0; tick();
        s = 2'b00; d = 12'h0FF;
        cen = 1'b1; tick();
        checks++;
        if (q8 !== 8'h3C || evt8 !== 1'b1) begin
            errors++; $display("FAIL hold_evt got q=%h evt=%b want q=3c evt=1", q8, evt8);
        end
        cen = 1'b0; tick();
        checks++;
        if (q8 !== 8'h3C || evt8 !== 1'b0) begin
            errors++; $display("FAIL hold_after got q=%h evt=%b want q=3c evt=0", q8, evt8);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL hold_seq got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [21:0] e, o;
        s = 2'b01; dsr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cen = 1'b1; tick(); cen = 1'b0; tick();
        end
        cen = 1'b1; rstn = 1'b0; tick();
        checks++;
        if (q8 !== 8'h00 || q12 !== 12'h000 || evt8 !== 1'b0) begin
            errors++; $display("FAIL reset_mid_shift got q8=%h q12=%h evt=%b want 00 000 0", q8, q12, evt8);
        end
        rstn = 1'b1; cen = 1'b0; tick();
        cen = 1'b1; tick(); cen = 1'b0; tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset_mid_seq got=%h want=%h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_shift_up();
        test_shift_down();
        test_mrn_vs_edge();
        test_level_mode();
        test_hold_event();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
